// File: rtl/hf_mode_sequencer_pkg.sv
// rtl/hf_mode_sequencer_pkg.sv - shared types and constants for the HF mode sequencer
`ifndef FPGA_CMD_SET_CONFREG
`define FPGA_CMD_SET_CONFREG 4'd1
`endif
`ifndef FPGA_CMD_TRACE_ENABLE
`define FPGA_CMD_TRACE_ENABLE 4'd2
`endif

package hf_mode_sequencer_pkg;

    localparam int FRAME_W = 16;
    localparam int CONF_W  = 9;

    localparam logic [3:0] CMD_SET_CONFREG   = `FPGA_CMD_SET_CONFREG;
    localparam logic [3:0] CMD_TRACE_ENABLE  = `FPGA_CMD_TRACE_ENABLE;

    localparam logic [2:0]        MAJOR_OFF  = 3'b111;
    localparam logic [CONF_W-1:0] CONF_RESET = {MAJOR_OFF, 2'b00, 4'b0000};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } seq_state_t;

    // A major change is anything that alters the top three bits of the config.
    function automatic logic is_major_change(input logic [CONF_W-1:0] cur,
                                             input logic [CONF_W-1:0] nxt);
        return cur[8:6] != nxt[8:6];
    endfunction

endpackage

// File: rtl/hf_mode_sequencer_if.sv
// rtl/hf_mode_sequencer_if.sv - command frame handshake between SPI receiver and sequencer
interface hf_mode_sequencer_if;
    import hf_mode_sequencer_pkg::*;

    logic               cmd_valid;
    logic [FRAME_W-1:0] cmd_frame;
    logic               cmd_ready;

    modport master (output cmd_valid, output cmd_frame, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_frame, output cmd_ready);

endinterface

// File: rtl/hf_mode_sequencer_timer.sv
// rtl/hf_mode_sequencer_timer.sv - loadable down-counter with done flag for phase timing
module hf_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on phase entry, then count down and park at zero so it never wraps.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/hf_mode_sequencer.sv
// rtl/hf_mode_sequencer.sv - glitch-free major-mode sequencing of the HF config word
module hf_mode_sequencer
    import hf_mode_sequencer_pkg::*;
#(
    parameter int GUARD_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic               ck_1356meg,
    input  logic               nrst,
    hf_mode_sequencer_if.slave cmd_if,
    output logic [CONF_W-1:0]  conf_word,
    output logic               trace_enable,
    output logic               drv_blank,
    output logic               ssp_mute,
    output logic               busy,
    output logic               cmd_drop
);

    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t        r_state;
    logic [CONF_W-1:0] r_conf;
    logic [CONF_W-1:0] r_pend;
    logic              r_trace;
    logic              r_drop;
    logic              r_blank;
    logic              r_mute;
    logic              r_busy;
    logic              r_ready;

    seq_state_t        w_state_nxt;
    logic [CONF_W-1:0] w_conf_nxt;
    logic [CONF_W-1:0] w_pend_nxt;
    logic              w_trace_nxt;
    logic              w_drop_nxt;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;
    logic              w_tmr_done;
    logic              w_accept;
    logic [3:0]        w_cmd;
    logic [11:0]       w_data;
    logic [2:0]        w_unused_data;

    assign w_accept      = cmd_if.cmd_valid & r_ready;
    assign w_cmd         = cmd_if.cmd_frame[15:12];
    assign w_data        = cmd_if.cmd_frame[11:0];
    assign w_unused_data = w_data[11:9];

    hf_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (ck_1356meg),
        .nrst       (nrst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Register state, config and every output so the mux gates never see decode glitches.
    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_conf  <= CONF_RESET;
            r_pend  <= CONF_RESET;
            r_trace <= 1'b0;
            r_drop  <= 1'b0;
            r_blank <= 1'b0;
            r_mute  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_conf  <= w_conf_nxt;
            r_pend  <= w_pend_nxt;
            r_trace <= w_trace_nxt;
            r_drop  <= w_drop_nxt;
            r_blank <= (w_state_nxt == ST_BLANK) || (w_state_nxt == ST_COMMIT);
            r_mute  <= (w_state_nxt != ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Next-state logic: decode accepted frames in IDLE and walk blank -> commit -> settle.
    always_comb begin
        w_state_nxt = r_state;
        w_conf_nxt  = r_conf;
        w_pend_nxt  = r_pend;
        w_trace_nxt = r_trace;
        w_drop_nxt  = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd == CMD_TRACE_ENABLE) begin
                        w_trace_nxt = w_data[0];
                    end else if (w_cmd == CMD_SET_CONFREG) begin
                        if (!is_major_change(r_conf, w_data[8:0])) begin
                            w_conf_nxt = w_data[8:0];
                        end else begin
                            w_pend_nxt  = w_data[8:0];
                            w_state_nxt = ST_BLANK;
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = GUARD_LOAD;
                        end
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_conf_nxt = r_pend;
                // Switching off needs no settle: nothing is driving the SSP afterwards.
                if ((r_pend[8:6] == MAJOR_OFF) || (SETTLE_CYCLES == 0)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd_if.cmd_ready = r_ready;
    assign conf_word        = r_conf;
    assign trace_enable     = r_trace;
    assign drv_blank        = r_blank;
    assign ssp_mute         = r_mute;
    assign busy             = r_busy;
    assign cmd_drop         = r_drop;

endmodule
